// File: rtl/hop_pkg.sv
// Shared types and constants for the hop-chain self-check monitor.
package hop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } hop_state_e;

    localparam int HOP_DEFAULT_LATENCY = 3;

    // Widest supported index; narrower monitors take the low bits of the marker.
    localparam int HOP_MAX_CNT_W = 32;
    localparam logic [HOP_MAX_CNT_W-1:0] HOP_IDX_NONE = {HOP_MAX_CNT_W{1'b1}};

endpackage

// File: rtl/hop_chain_monitor_if.sv
// Control, stimulus and result bundle between a hop-chain driver and its monitor.
interface hop_chain_monitor_if #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);

    logic             enable;
    logic             abort;
    logic [CNT_W-1:0] run_len;
    logic             stim;
    logic             chain_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_err_idx;

    modport master (
        output enable, abort, run_len, stim, chain_out,
        input  busy, done, pass, err_cnt, first_err_idx
    );

    modport slave (
        input  enable, abort, run_len, stim, chain_out,
        output busy, done, pass, err_cnt, first_err_idx
    );

endinterface

// File: rtl/hop_delay_line.sv
// DEPTH-stage shift register; o_q is i_d from DEPTH cycles earlier.
module hop_delay_line
    import hop_pkg::*;
#(
    parameter int DEPTH = HOP_DEFAULT_LATENCY
) (
    input  logic clock0,
    input  logic rst2,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sh;

    // Shift every cycle regardless of monitor state so the copy is always primed.
    always_ff @(posedge clock0 or negedge rst2) begin
        if (!rst2) begin
            r_sh <= {DEPTH{1'b0}};
        end else begin
            r_sh <= DEPTH'({r_sh, i_d});
        end
    end

    assign o_q = r_sh[DEPTH-1];

endmodule

// File: rtl/hop_chain_monitor.sv
// Compares the hop-chain output against a delayed copy of its stimulus over a
// programmable window and reports pass/fail, saturating error count and first failing index.
module hop_chain_monitor
    import hop_pkg::*;
#(
    parameter int LATENCY = HOP_DEFAULT_LATENCY,
    parameter int CNT_W   = 16,
    parameter int ERR_W   = 8
) (
    input logic                clock0,
    input logic                rst2,
    hop_chain_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] IDX_NONE  = HOP_IDX_NONE[CNT_W-1:0];
    localparam logic [CNT_W-1:0] IDX_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] IDX_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ZERO  = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
    localparam logic [3:0]       FILL_LAST = 4'(LATENCY - 1);

    hop_state_e       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_first_err_idx;
    logic [CNT_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_idx;
    logic [3:0]       r_fill_cnt;

    logic             w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;
    logic             w_last_idx;

    hop_delay_line #(
        .DEPTH (LATENCY)
    ) u_exp_line (
        .clock0 (clock0),
        .rst2   (rst2),
        .i_d    (bus.stim),
        .o_q    (w_exp)
    );

    assign w_last_idx = (r_idx == (r_run_len - IDX_ONE));

    // Mismatch detection and saturating next error count.
    always_comb begin
        w_mismatch = 1'b0;
        w_err_next = r_err_cnt;
        if (r_state == CHECK) begin
            w_mismatch = bus.chain_out ^ w_exp;
        end else begin
            w_mismatch = 1'b0;
        end
        if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
            w_err_next = r_err_cnt + ERR_ONE;
        end else begin
            w_err_next = r_err_cnt;
        end
    end

    // Run-control FSM with registered status and result outputs.
    always_ff @(posedge clock0 or negedge rst2) begin
        if (!rst2) begin
            r_state         <= IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_cnt       <= ERR_ZERO;
            r_first_err_idx <= IDX_NONE;
            r_run_len       <= IDX_ZERO;
            r_idx           <= IDX_ZERO;
            r_fill_cnt      <= 4'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.enable) begin
                        r_state         <= FILL;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_err_cnt       <= ERR_ZERO;
                        r_first_err_idx <= IDX_NONE;
                        r_run_len       <= bus.run_len;
                        r_idx           <= IDX_ZERO;
                        r_fill_cnt      <= 4'd0;
                    end
                end
                FILL: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else if (r_fill_cnt == FILL_LAST) begin
                        if (r_run_len == IDX_ZERO) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err_cnt == ERR_ZERO);
                        end else begin
                            r_state <= CHECK;
                            r_idx   <= IDX_ZERO;
                        end
                    end else begin
                        r_fill_cnt <= r_fill_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end else begin
                        r_err_cnt <= w_err_next;
                        // err_cnt never wraps back to zero, so zero means no mismatch yet.
                        if (w_mismatch && (r_err_cnt == ERR_ZERO)) begin
                            r_first_err_idx <= r_idx;
                        end
                        if (w_last_idx) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == ERR_ZERO);
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.pass          = r_pass;
    assign bus.err_cnt       = r_err_cnt;
    assign bus.first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_hop_chain_monitor.sv
// Self-checking bench: table-driven runs, abort/reset sequences and randomized runs
// checked against a per-index mismatch model of the monitor.
module tb_hop_chain_monitor;

    localparam int L  = 3;
    localparam int CW = 16;
    localparam int EW = 8;

    logic clock0 = 1'b0;
    logic rst2   = 1'b0;

    hop_chain_monitor_if #(.CNT_W(CW), .ERR_W(EW)) mon_if ();

    hop_chain_monitor #(.LATENCY(L), .CNT_W(CW), .ERR_W(EW)) dut (
        .clock0 (clock0),
        .rst2   (rst2),
        .bus    (mon_if)
    );

    always #5 clock0 = ~clock0;

    typedef struct {
        int n;
        int mode;
        int fidx;
        int abort_at;
        int en_at;
        int pat;
        bit x_pass;
        int x_err;
        int x_first;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit stim_h [0:131071];
    bit fl     [0:65535];
    bit pat8   [0:7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit next_stim(input int pat);
        if (pat == 0) return pat8[cyc % 8];
        return 1'($urandom);
    endfunction

    // One clock of stimulus: the chain is modelled as stim delayed L cycles, optionally inverted.
    task automatic drive(input bit s, input bit f);
        mon_if.stim = s;
        stim_h[cyc] = s;
        mon_if.chain_out = ((cyc >= L) ? stim_h[cyc - L] : 1'b0) ^ f;
        @(posedge clock0);
        #1;
        cyc++;
    endtask

    task automatic gen_flips(input int n, input int mode, input int fidx);
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       fl[i] = (i == fidx);
                2:       fl[i] = 1'b1;
                3:       fl[i] = ($urandom_range(0, 3) == 0);
                4:       fl[i] = (i == fidx) || (i == fidx + 2);
                default: fl[i] = 1'b0;
            endcase
        end
    endtask

    // Expected results: count flipped indices in the compared window, saturate at 255.
    task automatic model(input int n, input int abort_at, output bit p, output int e, output int f);
        int cnt;
        int top;
        bit ab;
        cnt = 0;
        f   = 32'h0000FFFF;
        ab  = (abort_at >= 0) && (abort_at < n);
        top = ab ? abort_at : n;
        for (int i = 0; i < top; i++) begin
            if (fl[i]) begin
                if (cnt == 0) f = i;
                cnt++;
            end
        end
        e = (cnt > 255) ? 255 : cnt;
        p = !ab && (cnt == 0);
    endtask

    task automatic do_run(input int n, input int abort_at, input int en_at, input int pat,
                          input bit xp, input int xe, input int xf, input string nm);
        int bad_t;
        int tot;
        int i;
        bit f;
        bit aborted;
        bad_t   = 0;
        tot     = L + n;
        aborted = 1'b0;
        mon_if.enable  = 1'b1;
        mon_if.abort   = 1'b0;
        mon_if.run_len = 16'(n);
        drive(next_stim(pat), 1'b0);
        mon_if.enable = 1'b0;
        chk({nm, "/start_busy"}, 32'(mon_if.busy), 32'd1);
        chk({nm, "/start_done"}, 32'(mon_if.done), 32'd0);
        chk({nm, "/start_err"}, 32'(mon_if.err_cnt), 32'd0);
        chk({nm, "/start_first"}, 32'(mon_if.first_err_idx), 32'h0000FFFF);
        for (int t = 1; t <= tot; t++) begin
            i = t - L - 1;
            f = (i >= 0) ? fl[i] : 1'b0;
            mon_if.abort   = (i >= 0) && (i == abort_at);
            mon_if.enable  = (i >= 0) && (i == en_at);
            mon_if.run_len = 16'($urandom);
            drive(next_stim(pat), f);
            mon_if.enable = 1'b0;
            if (mon_if.abort) begin
                mon_if.abort = 1'b0;
                aborted = 1'b1;
                break;
            end
            if ((mon_if.busy !== (t < tot)) || (mon_if.done !== (t == tot))) bad_t++;
        end
        chk({nm, "/timing_errs"}, 32'(bad_t), 32'd0);
        if (aborted) begin
            chk({nm, "/abort_busy"}, 32'(mon_if.busy), 32'd0);
            chk({nm, "/abort_done"}, 32'(mon_if.done), 32'd0);
            chk({nm, "/abort_pass"}, 32'(mon_if.pass), 32'd0);
            chk({nm, "/abort_err"}, 32'(mon_if.err_cnt), 32'(xe));
            chk({nm, "/abort_first"}, 32'(mon_if.first_err_idx), 32'(xf));
            drive(next_stim(pat), 1'b0);
            chk({nm, "/abort_idle"}, 32'(mon_if.busy), 32'd0);
        end else begin
            chk({nm, "/pass"}, 32'(mon_if.pass), 32'(xp));
            chk({nm, "/err"}, 32'(mon_if.err_cnt), 32'(xe));
            chk({nm, "/first"}, 32'(mon_if.first_err_idx), 32'(xf));
            drive(next_stim(pat), 1'b0);
            chk({nm, "/hold_done"}, 32'(mon_if.done), 32'd1);
            chk({nm, "/hold_err"}, 32'(mon_if.err_cnt), 32'(xe));
        end
    endtask

    initial begin
        bit mp;
        int me;
        int mf;
        int n;
        int ab;
        int en;
        int dcount;

        //            n    mode fidx abort en  pat pass err  first
        tbl[0]  = '{8,   0, 0, -1, -1, 0, 1'b1, 0,   32'hFFFF};
        tbl[1]  = '{8,   1, 5, -1, -1, 0, 1'b0, 1,   5};
        tbl[2]  = '{300, 2, 0, -1, -1, 1, 1'b0, 255, 0};
        tbl[3]  = '{0,   0, 0, -1, -1, 0, 1'b1, 0,   32'hFFFF};
        tbl[4]  = '{8,   4, 1,  4, -1, 0, 1'b0, 2,   1};
        tbl[5]  = '{8,   0, 0, -1, -1, 0, 1'b1, 0,   32'hFFFF};
        tbl[6]  = '{12,  0, 0, -1,  3, 1, 1'b1, 0,   32'hFFFF};
        tbl[7]  = '{12,  1, 7,  5,  5, 1, 1'b0, 0,   32'hFFFF};
        tbl[8]  = '{1,   1, 0, -1, -1, 1, 1'b0, 1,   0};
        tbl[9]  = '{10,  1, 9, -1, -1, 1, 1'b0, 1,   9};
        tbl[10] = '{255, 2, 0, -1, -1, 1, 1'b0, 255, 0};
        tbl[11] = '{256, 2, 0, -1, -1, 1, 1'b0, 255, 0};
        tbl[12] = '{254, 2, 0, -1, -1, 1, 1'b0, 254, 0};
        tbl[13] = '{5,   4, 0, -1, -1, 1, 1'b0, 2,   0};

        mon_if.enable    = 1'b0;
        mon_if.abort     = 1'b0;
        mon_if.run_len   = 16'd0;
        mon_if.stim      = 1'b0;
        mon_if.chain_out = 1'b0;

        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0);
        chk("reset_busy", 32'(mon_if.busy), 32'd0);
        chk("reset_done", 32'(mon_if.done), 32'd0);
        chk("reset_pass", 32'(mon_if.pass), 32'd0);
        chk("reset_err", 32'(mon_if.err_cnt), 32'd0);
        chk("reset_first", 32'(mon_if.first_err_idx), 32'h0000FFFF);
        rst2 = 1'b1;
        for (int k = 0; k < 4; k++) drive(next_stim(0), 1'b0);

        for (int k = 0; k < 14; k++) begin
            gen_flips(tbl[k].n, tbl[k].mode, tbl[k].fidx);
            do_run(tbl[k].n, tbl[k].abort_at, tbl[k].en_at, tbl[k].pat,
                   tbl[k].x_pass, tbl[k].x_err, tbl[k].x_first, $sformatf("row%0d", k));
        end

        // Asynchronous reset in the middle of CHECK, then confirm no stray done pulse.
        gen_flips(20, 2, 0);
        mon_if.enable  = 1'b1;
        mon_if.run_len = 16'd20;
        drive(next_stim(1), 1'b0);
        mon_if.enable = 1'b0;
        for (int t = 1; t <= L + 5; t++) drive(next_stim(1), (t > L) ? fl[t - L - 1] : 1'b0);
        chk("rst_pre_err", 32'(mon_if.err_cnt), 32'd5);
        rst2 = 1'b0;
        #1;
        chk("rst_async_busy", 32'(mon_if.busy), 32'd0);
        chk("rst_async_done", 32'(mon_if.done), 32'd0);
        chk("rst_async_pass", 32'(mon_if.pass), 32'd0);
        chk("rst_async_err", 32'(mon_if.err_cnt), 32'd0);
        chk("rst_async_first", 32'(mon_if.first_err_idx), 32'h0000FFFF);
        drive(next_stim(1), 1'b0);
        drive(next_stim(1), 1'b0);
        rst2 = 1'b1;
        dcount = 0;
        for (int t = 0; t < 30; t++) begin
            drive(next_stim(1), 1'b0);
            if (mon_if.done || mon_if.busy) dcount++;
        end
        chk("rst_no_done", 32'(dcount), 32'd0);

        // Randomized runs against the index-level model.
        for (int r = 0; r < 25; r++) begin
            n  = $urandom_range(0, 40);
            ab = ((n > 0) && ($urandom_range(0, 3) == 0)) ? $urandom_range(0, n - 1) : -1;
            en = ((n > 0) && ($urandom_range(0, 2) == 0)) ? $urandom_range(0, n - 1) : -1;
            gen_flips(n, 3, 0);
            model(n, ab, mp, me, mf);
            do_run(n, ab, en, 1, mp, me, mf, $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hop_chain_monitor.md
Name: hop_chain_monitor

Overview:
- Downstream consumer of the three-flop hop chain (start -> ff1 -> ff2 -> ff3).
- Keeps a delayed copy of the stimulus that drives the chain's start input.
- Compares that copy bit-by-bit against the chain output (ff3) over a programmable window, then reports pass/fail, a saturating error count and the index of the first mismatch.
- Used as the on-chip self-check for hop-latency benchmark designs.

Parameters:
- LATENCY, 3, chain depth in cycles from stim to chain_out; legal range 1..8.
- CNT_W, 16, width of run length and compare index.
- ERR_W, 8, width of the error counter.

Ports:
- clock0  input  1  clock.
- rst2  input  1  reset.
- enable  input  1  synchronous pulse that starts a check run.
- abort  input  1  synchronous; cancels a run in progress.
- run_len  input  CNT_W  number of compared cycles; sampled on accepted enable.
- stim  input  1  value driven onto the chain's start input this cycle.
- chain_out  input  1  chain output (ff3).
- busy  output  1  high in FILL or CHECK.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 when err_cnt == 0.
- err_cnt  output  ERR_W  mismatch count, saturating.
- first_err_idx  output  CNT_W  compare index of the first mismatch; all-ones if none.

Behaviour:
- Interface: reset rst2, asynchronous, active-low; clock clock0.
- Reset values: state IDLE, busy 0, done 0, pass 0, err_cnt 0, first_err_idx all-ones, delay line all zeros, counters 0.
- Delay line: LATENCY-deep shift register of stim. It shifts every cycle in every state. Its output exp equals stim from LATENCY cycles earlier.
- State IDLE: enable=1 -> FILL. On the same edge: latch run_len, clear err_cnt, set first_err_idx all-ones, pass 0, load fill_cnt=0.
- State FILL: lasts exactly LATENCY cycles. Let F be the first FILL cycle. Then:
  - compare index i checks chain_out at cycle F+LATENCY+i against stim sampled at cycle F+i;
  - at the end of FILL, go to CHECK, or straight to DONE if the latched run_len == 0.
- State CHECK: each cycle, compare chain_out with exp at index idx (starting at 0).
  - On mismatch: err_cnt increments, holding at 2^ERR_W-1 once saturated.
  - On the first mismatch of the run: first_err_idx <= idx.
  - After the compare with idx == run_len-1 -> DONE.
- State DONE: done=1, pass=(err_cnt==0), and all results hold. enable=1 -> FILL with the same clearing as in IDLE. done drops on the next cycle.
- enable while busy is ignored.
- abort=1 in FILL or CHECK -> IDLE:
  - busy 0, done 0, pass 0;
  - err_cnt and first_err_idx keep their partial values.
- abort in IDLE or DONE is ignored.
- enable and abort in the same cycle: abort wins if busy; otherwise enable is accepted.
- rst2 asserted mid-run: immediate return to reset values, and no done pulse.
- A run_len change during a run has no effect.
- Maximum run: run_len = 2^CNT_W-1. The idx counter must not wrap before DONE.
- Latency from accepted enable to done=1: LATENCY + run_len + 1 cycles.

Decomposition:
- Shared package hop_pkg holds:
  - the state enum {IDLE, FILL, CHECK, DONE};
  - the constant HOP_DEFAULT_LATENCY = 3;
  - the all-ones helper constant for first_err_idx.
- One sub-module, hop_delay_line (parameter DEPTH): LATENCY-deep shift register with rst2 asynchronous active-low clear. It is instantiated once for exp.

Test Plan:
1. Pass case: LATENCY=3, stim = 1,0,1,1,0,0,1,0 repeating, chain_out = stim delayed 3 cycles, run_len=8, enable pulse.
   -> busy for 11 cycles; done=1 on cycle 12; pass=1, err_cnt=0, first_err_idx=16'hFFFF.
2. Single error: same stimulus, chain_out inverted only at compare index 5.
   -> done with pass=0, err_cnt=1, first_err_idx=5.
3. Saturation: ERR_W=8, run_len=300, chain_out = ~exp every cycle.
   -> err_cnt=255, first_err_idx=0, pass=0.
4. Zero length: run_len=0, enable.
   -> FILL for 3 cycles, then done=1, pass=1, err_cnt=0.
5. Abort and reset:
   - abort asserted at idx=4 with 2 errors so far -> IDLE, done=0, err_cnt=2 held;
   - rerun with enable -> err_cnt cleared to 0;
   - rst2 low during CHECK -> all outputs at reset values asynchronously.
6. Enable ignored: enable pulsed during CHECK and again in the same cycle as abort.
   -> the first pulse is ignored and the run is unaffected; in the same-cycle case abort wins and the state goes to IDLE.
